irq_ctl: RTL and testbench
==========================

# irq_ctl

Parametrised interrupt controller between up to 8 peripheral request lines and the 65C02 core's `IRQ`/`NMI` inputs. Each channel has its own mask, edge/level mode and IRQ/NMI routing, and the controller returns a priority vector that the CPU reads over its data bus. Register reads are registered (one-cycle latency) so the block sits on the CPU bus exactly like synchronous RAM.

## Interface
Parameters:
- `CHANNELS`, 8: number of request inputs, 1..8; register bits at index ≥ `CHANNELS` read 0 and ignore writes.
- `SYNC_STAGES`, 2: input synchroniser depth, 0..3 (0 = inputs already in `clk` domain).

Ports:
- `clk` in 1: CPU clock.
- `RST` in 1: asynchronous, active-high reset.
- `cs` in 1: chip select, decoded from CPU `AD` by the system.
- `AD` in 3: register offset (CPU `AD[2:0]`).
- `DI` in 8: write data (CPU `DO`).
- `DO` out 8: read data to CPU `DI`, registered.
- `WE` in 1: CPU write enable.
- `RDY` in 1: CPU ready; bus accesses take effect only when 1.
- `req` in `CHANNELS`: peripheral requests, active-high, may be asynchronous.
- `IRQ` out 1: registered, to CPU `IRQ`.
- `NMI` out 1: registered, to CPU `NMI`.

## Operation
- Register map (offset: name, access):
  - 0 PEND: R; write-1-clear (edge channels only).
  - 1 MASK: RW; 1 = enabled.
  - 2 MODE: RW; 1 = edge, 0 = level.
  - 3 NMISEL: RW; 1 = route to NMI.
  - 4 VEC: R with side effect; bit7 = 1 when nothing pending/enabled on IRQ route, else bits[2:0] = index; bits[6:3] = 0.
  - 5 RAW: R; synchronised `req`.
  - 6 SET: W; write-1-set of PEND (edge channels only).
  - 7: reads 0, writes ignored.
- Access strobe: `acc = cs & RDY`; write when `acc & WE`, read when `acc & ~WE`.
- Level channel: PEND bit = synchronised `req` each cycle; W1C/SET ignored.
- Edge channel: rising edge of synchronised `req` sets PEND; stays set until cleared by W1C, SET-then-clear, or VEC read-ack.
- Priority: lowest index wins; only `PEND & MASK & ~NMISEL` participates in VEC/IRQ.
- VEC read-ack: reading offset 4 clears the reported channel's PEND bit when that channel is edge mode; level channels unaffected.
- `IRQ <= |(PEND & MASK & ~NMISEL)`; `NMI <= |(PEND & MASK & NMISEL)`.
- Mode change edge→level: PEND bit reloads from input next cycle. Level→edge: PEND keeps current value; edge detector history keeps tracking continuously, so no spurious edge.

## Timing
- Reset: PEND, MASK, MODE, NMISEL = 0; synchroniser and edge history = 0; `DO` = 0; `IRQ` = `NMI` = 0.
- `req` to PEND: `SYNC_STAGES`+1 cycles (edge detect registered); PEND to `IRQ`/`NMI`: +1 cycle.
- Read: `AD` presented in cycle n with `acc`, `DO` valid after edge n+1 and held until next read; `RDY`=0 holds `DO` and suppresses side effects.
- VEC value captured in `DO` is the pre-ack value; ack clear happens at the same edge.
- Same-cycle set event and clear (W1C or ack) on one bit: set wins.
- Same-cycle SET write and edge: bit set.
- Writes to MASK/MODE/NMISEL visible in `IRQ`/`NMI` one cycle later.
- Reset asserted mid-access: all state returns to reset values immediately; no partial write retained.

## Structure
- Package `irq_pkg`: register offset constants (`IRQ_PEND`…`IRQ_SET`), `VEC_NONE = 8'h80`, max channel constant 8.
- Sub-module `irq_prio`: combinational lowest-index priority encoder, `CHANNELS`-wide, outputs `valid` and 3-bit index; instantiated once.
- Synchroniser is a generate loop inside `irq_ctl`.

## Test plan
- Reset: assert `RST` mid-cycle with `req`=8'hFF → all outputs 0, PEND/MASK read 8'h00 after release.
- Edge + ack: MODE=8'hFF, MASK=8'h0C, pulse `req[3]` and `req[2]` → `IRQ`=1 after 4 cycles (SYNC_STAGES=2); VEC reads 8'h02, then 8'h03, then 8'h80; `IRQ` drops.
- Level: MODE=0, MASK=8'h01, hold `req[0]` → VEC read leaves PEND=8'h01; deassert `req[0]` → PEND=8'h00 after 3 cycles, `IRQ`=0 one cycle later.
- NMI routing: NMISEL=8'h80, MASK=8'h80, edge on `req[7]` → `NMI`=1, `IRQ`=0, VEC=8'h80.
- Collision: SET write 8'h10 and W1C to PEND bit4 in adjacent cycles, plus edge on bit4 in the W1C cycle → PEND bit4 remains 1.
- `CHANNELS`=3: write MASK 8'hFF → reads 8'h07; `RDY`=0 during VEC read → no ack, `DO` unchanged.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets and the
// "nothing pending" vector code.
package irq_pkg;

    localparam logic [2:0] IRQ_PEND   = 3'd0;
    localparam logic [2:0] IRQ_MASK   = 3'd1;
    localparam logic [2:0] IRQ_MODE   = 3'd2;
    localparam logic [2:0] IRQ_NMISEL = 3'd3;
    localparam logic [2:0] IRQ_VEC    = 3'd4;
    localparam logic [2:0] IRQ_RAW    = 3'd5;
    localparam logic [2:0] IRQ_SET    = 3'd6;

    localparam logic [7:0] VEC_NONE   = 8'h80;
    localparam int         IRQ_MAX_CH = 8;

endpackage

// File: rtl/irq_prio.sv
// Lowest-index-wins priority encoder over the active IRQ-routed channels.
module irq_prio
    import irq_pkg::*;
#(
    parameter int CHANNELS = 8
) (
    input  logic [CHANNELS-1:0] bits,
    output logic                valid,
    output logic [2:0]          idx
);

    always_comb begin
        valid = |bits;
        idx   = 3'd0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: per-channel mask, edge/level mode and IRQ/NMI routing,
// with a registered-read register file that behaves like synchronous RAM.
module irq_ctl
    import irq_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                cs,
    input  logic [2:0]          AD,
    input  logic [7:0]          DI,
    output logic [7:0]          DO,
    input  logic                WE,
    input  logic                RDY,
    input  logic [CHANNELS-1:0] req,
    output logic                IRQ,
    output logic                NMI
);

    logic [CHANNELS-1:0] req_s, req_d;
    logic [CHANNELS-1:0] pend, mask, mode, nmisel;
    logic [CHANNELS-1:0] act_irq, set_ev, clr_ev, pend_nxt;
    logic                acc, wr, rd, vec_valid;
    logic [2:0]          vec_idx;
    logic [7:0]          rdata;

    function automatic logic [7:0] pad8(input logic [CHANNELS-1:0] v);
        pad8 = '0;
        pad8[CHANNELS-1:0] = v;
    endfunction

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = req;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][CHANNELS-1:0] stg;
            always_ff @(posedge clk or posedge RST) begin
                if (RST) begin
                    stg <= '0;
                end else begin
                    stg[0] <= req;
                    for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
                end
            end
            assign req_s = stg[SYNC_STAGES-1];
        end
    endgenerate

    assign acc     = cs & RDY;
    assign wr      = acc & WE;
    assign rd      = acc & ~WE;
    assign act_irq = pend & mask & ~nmisel;

    irq_prio #(.CHANNELS(CHANNELS)) u_prio (
        .bits  (act_irq),
        .valid (vec_valid),
        .idx   (vec_idx)
    );

    // Set events are OR-ed in after clears so a coincident set always wins.
    always_comb begin
        set_ev = req_s & ~req_d;
        clr_ev = '0;
        if (wr && AD == IRQ_SET)  set_ev = set_ev | DI[CHANNELS-1:0];
        if (wr && AD == IRQ_PEND) clr_ev = DI[CHANNELS-1:0];
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd && AD == IRQ_VEC && vec_valid && vec_idx == 3'(i)) clr_ev[i] = 1'b1;
        end
        pend_nxt = (mode & ((pend & ~clr_ev) | set_ev)) | (~mode & req_s);
    end

    always_comb begin
        rdata = 8'h00;
        case (AD)
            IRQ_PEND:   rdata = pad8(pend);
            IRQ_MASK:   rdata = pad8(mask);
            IRQ_MODE:   rdata = pad8(mode);
            IRQ_NMISEL: rdata = pad8(nmisel);
            IRQ_VEC:    rdata = vec_valid ? {5'b0, vec_idx} : VEC_NONE;
            IRQ_RAW:    rdata = pad8(req_s);
            default:    rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            req_d  <= '0;
            pend   <= '0;
            mask   <= '0;
            mode   <= '0;
            nmisel <= '0;
            DO     <= 8'h00;
            IRQ    <= 1'b0;
            NMI    <= 1'b0;
        end else begin
            req_d <= req_s;
            pend  <= pend_nxt;
            if (wr && AD == IRQ_MASK)   mask   <= DI[CHANNELS-1:0];
            if (wr && AD == IRQ_MODE)   mode   <= DI[CHANNELS-1:0];
            if (wr && AD == IRQ_NMISEL) nmisel <= DI[CHANNELS-1:0];
            if (rd) DO <= rdata;
            IRQ <= |act_irq;
            NMI <= |(pend & mask & nmisel);
        end
    end

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: an 8-channel instance for the main features and
// a 3-channel instance for unused-bit masking and RDY stalls.
module tb_irq_ctl;
    import irq_pkg::*;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       cs = 1'b0, cs3 = 1'b0, WE = 1'b0, RDY = 1'b1;
    logic [2:0] bus_ad = 3'd0;
    logic [7:0] bus_di = 8'h00;
    logic [7:0] rdata, rdata3;
    logic [7:0] req = 8'h00;
    logic [2:0] req3 = 3'b000;
    logic       irq, nmi, irq3, nmi3;
    logic [7:0] q;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    irq_ctl #(.CHANNELS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .RST(RST), .cs(cs), .AD(bus_ad), .DI(bus_di), .DO(rdata),
        .WE(WE), .RDY(RDY), .req(req), .IRQ(irq), .NMI(nmi)
    );

    irq_ctl #(.CHANNELS(3), .SYNC_STAGES(2)) dut3 (
        .clk(clk), .RST(RST), .cs(cs3), .AD(bus_ad), .DI(bus_di), .DO(rdata3),
        .WE(WE), .RDY(RDY), .req(req3), .IRQ(irq3), .NMI(nmi3)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic sel3, input logic [2:0] a, input logic [7:0] d);
        cs = ~sel3; cs3 = sel3; WE = 1'b1; bus_ad = a; bus_di = d;
        tick();
        cs = 1'b0; cs3 = 1'b0; WE = 1'b0;
    endtask

    task automatic rd(input logic sel3, input logic [2:0] a, output logic [7:0] v);
        cs = ~sel3; cs3 = sel3; WE = 1'b0; bus_ad = a;
        tick();
        v = sel3 ? rdata3 : rdata;
        cs = 1'b0; cs3 = 1'b0;
    endtask

    task automatic test_reset();
        req = 8'hFF;
        wr(0, IRQ_MASK, 8'hFF);
        tick(4);
        rd(0, IRQ_MASK, q);
        // Start a write, then assert reset mid-cycle before the edge lands.
        cs = 1'b1; WE = 1'b1; bus_ad = IRQ_MODE; bus_di = 8'hFF;
        #3 RST = 1'b1;
        #1;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_cmp++; if (nmi !== 1'b0) begin n_err++; $display("FAIL reset_nmi got %b want 0", nmi); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL reset_do got %h want 00", rdata); end
        req = 8'h00; cs = 1'b0; WE = 1'b0;
        tick(3);
        RST = 1'b0;
        tick();
        rd(0, IRQ_PEND, q);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_pend got %h want 00", q); end
        rd(0, IRQ_MASK, q);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_mask got %h want 00", q); end
    endtask

    task automatic test_edge_ack();
        wr(0, IRQ_MODE, 8'hFF);
        wr(0, IRQ_MASK, 8'h0C);
        req = 8'h0C;
        tick();
        req = 8'h00;
        tick(2);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_early got %b want 0", irq); end
        tick();
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_irq got %b want 1", irq); end
        rd(0, IRQ_VEC, q);
        n_cmp++; if (q !== 8'h02) begin n_err++; $display("FAIL edge_vec1 got %h want 02", q); end
        rd(0, IRQ_VEC, q);
        n_cmp++; if (q !== 8'h03) begin n_err++; $display("FAIL edge_vec2 got %h want 03", q); end
        rd(0, IRQ_VEC, q);
        n_cmp++; if (q !== 8'h80) begin n_err++; $display("FAIL edge_vec3 got %h want 80", q); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_drop got %b want 0", irq); end
    endtask

    task automatic test_level();
        wr(0, IRQ_MODE, 8'h00);
        wr(0, IRQ_MASK, 8'h01);
        req = 8'h01;
        tick(4);
        rd(0, IRQ_VEC, q);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL lvl_vec got %h want 00", q); end
        rd(0, IRQ_PEND, q);
        n_cmp++; if (q !== 8'h01) begin n_err++; $display("FAIL lvl_pend got %h want 01", q); end
        rd(0, IRQ_RAW, q);
        n_cmp++; if (q !== 8'h01) begin n_err++; $display("FAIL lvl_raw got %h want 01", q); end
        wr(0, IRQ_SET, 8'h02);
        rd(0, IRQ_PEND, q);
        n_cmp++; if (q !== 8'h01) begin n_err++; $display("FAIL lvl_set_ignored got %h want 01", q); end
        req = 8'h00;
        tick(3);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_irq_hold got %b want 1", irq); end
        rd(0, IRQ_PEND, q);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL lvl_pend_clr got %h want 00", q); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_irq_drop got %b want 0", irq); end
    endtask

    task automatic test_nmi();
        wr(0, IRQ_MASK, 8'h00);
        wr(0, IRQ_MODE, 8'hFF);
        wr(0, IRQ_NMISEL, 8'h80);
        wr(0, IRQ_MASK, 8'h80);
        req = 8'h80;
        tick();
        req = 8'h00;
        tick(3);
        n_cmp++; if (nmi !== 1'b1) begin n_err++; $display("FAIL nmi_set got %b want 1", nmi); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL nmi_irq got %b want 0", irq); end
        rd(0, IRQ_VEC, q);
        n_cmp++; if (q !== 8'h80) begin n_err++; $display("FAIL nmi_vec got %h want 80", q); end
        tick();
        n_cmp++; if (nmi !== 1'b1) begin n_err++; $display("FAIL nmi_no_ack got %b want 1", nmi); end
        wr(0, IRQ_PEND, 8'h80);
    endtask

    task automatic test_collision();
        req = 8'h10;
        tick();
        req = 8'h00;
        wr(0, IRQ_SET, 8'h10);
        wr(0, IRQ_PEND, 8'h10);
        rd(0, IRQ_PEND, q);
        n_cmp++; if (q !== 8'h10) begin n_err++; $display("FAIL coll_pend got %h want 10", q); end
        wr(0, IRQ_PEND, 8'h10);
        rd(0, IRQ_PEND, q);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL coll_w1c got %h want 00", q); end
    endtask

    task automatic test_ch3();
        wr(1, IRQ_MODE, 8'hFF);
        wr(1, IRQ_MASK, 8'hFF);
        rd(1, IRQ_MASK, q);
        n_cmp++; if (q !== 8'h07) begin n_err++; $display("FAIL ch3_mask got %h want 07", q); end
        wr(1, IRQ_SET, 8'hFF);
        rd(1, IRQ_PEND, q);
        n_cmp++; if (q !== 8'h07) begin n_err++; $display("FAIL ch3_pend got %h want 07", q); end
        cs3 = 1'b1; WE = 1'b0; RDY = 1'b0; bus_ad = IRQ_VEC;
        tick();
        cs3 = 1'b0; RDY = 1'b1;
        n_cmp++; if (rdata3 !== 8'h07) begin n_err++; $display("FAIL ch3_rdy_hold got %h want 07", rdata3); end
        rd(1, IRQ_VEC, q);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL ch3_vec0 got %h want 00", q); end
        rd(1, IRQ_VEC, q);
        n_cmp++; if (q !== 8'h01) begin n_err++; $display("FAIL ch3_vec1 got %h want 01", q); end
    endtask

    initial begin
        tick(3);
        RST = 1'b0;
        tick();
        test_reset();
        test_edge_ack();
        test_level();
        test_nmi();
        test_collision();
        test_ch3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
